// File: rtl/vector_stable_filter_if.sv
// Vector filter bus: synchronized input word, glitch clear,
// and the filtered value with its status outputs.
interface vector_stable_filter_if #(
  parameter int pWIDTH     = 18,
  parameter int pCNT_WIDTH = 16
);
  logic [pWIDTH-1:0]     ivector;
  logic                  iclr_glitch;
  logic [pWIDTH-1:0]     ovector;
  logic                  ochange;
  logic                  ostable;
  logic [pCNT_WIDTH-1:0] oglitch_cnt;

  modport master (
    output ivector,
    output iclr_glitch,
    input  ovector,
    input  ochange,
    input  ostable,
    input  oglitch_cnt
  );

  modport slave (
    input  ivector,
    input  iclr_glitch,
    output ovector,
    output ochange,
    output ostable,
    output oglitch_cnt
  );
endinterface

// File: rtl/vector_stable_filter.sv
// Accepts a synchronized word only after N identical samples,
// strobes on change and counts abandoned candidates.
module vector_stable_filter #(
  parameter int                pWIDTH       = 18,
  parameter int                pSTABLE_CNT  = 4,
  parameter logic [pWIDTH-1:0] pRESET_VALUE = '0,
  parameter int                pCNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  vector_stable_filter_if.slave  bus
);
  localparam int CW = $clog2(pSTABLE_CNT + 1);
  localparam logic [CW-1:0] FULL = CW'(pSTABLE_CNT);
  localparam logic [CW-1:0] LAST = CW'(pSTABLE_CNT - 1);

  if (pSTABLE_CNT < 2) begin : g_chk
    $error("pSTABLE_CNT must be >= 2");
  end

  logic [pWIDTH-1:0]     cand;
  logic [CW-1:0]         cnt;
  logic [pWIDTH-1:0]     ovec;
  logic                  chg;
  logic [pCNT_WIDTH-1:0] glitch;
  logic                  miss;
  logic                  sat;

  assign miss = (bus.ivector != cand);
  assign sat  = (cnt == FULL);

  always_ff @(posedge clock) begin
    if (rst) begin
      cand   <= pRESET_VALUE;
      cnt    <= FULL;
      ovec   <= pRESET_VALUE;
      chg    <= 1'b0;
      glitch <= '0;
    end else begin
      chg <= 1'b0;
      if (miss) begin
        cand <= bus.ivector;
        cnt  <= CW'(1);
      end else if (!sat) begin
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          ovec <= cand;
          chg  <= (cand != ovec);
        end
      end
      // a saturated candidate being replaced is a real change, not a glitch
      if (bus.iclr_glitch) begin
        glitch <= '0;
      end else if (miss && !sat && glitch != '1) begin
        glitch <= glitch + pCNT_WIDTH'(1);
      end
    end
  end

  assign bus.ovector     = ovec;
  assign bus.ochange     = chg;
  assign bus.ostable     = sat;
  assign bus.oglitch_cnt = glitch;
endmodule
